// File: rtl/vga_timing_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_if
// Brief    : Raster timing bundle from vga_timing_gen to its consumers.
// Revision : 1.0
// ============================================================================
interface vga_timing_if;
    logic       pix_en;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       hSync;
    logic       vSync;
    logic       bright;
    logic       frame_tick;
    logic       game_tick;

    modport master (
        output pix_en, hCount, vCount, hSync, vSync, bright, frame_tick, game_tick
    );

    modport slave (
        input  pix_en, hCount, vCount, hSync, vSync, bright, frame_tick, game_tick
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : 640x480@60 VGA raster counters, syncs, bright, frame/game ticks.
// Revision : 1.0
// ============================================================================
module vga_timing_gen #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_TOTAL   = 800,
    parameter int unsigned V_TOTAL   = 525,
    parameter int unsigned FRAME_DIV = 2,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned V_VISIBLE = 480
) (
    input  wire logic        clk,
    input  wire logic        rst,
    vga_timing_if.master     vga
);

    localparam logic [3:0] c_div_last    = 4'(CLK_DIV - 1);
    localparam logic [9:0] c_h_last      = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_v_last      = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_h_sync_end  = 10'(H_SYNC);
    localparam logic [9:0] c_h_vis_start = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] c_h_vis_end   = 10'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [9:0] c_v_sync_end  = 10'(V_SYNC);
    localparam logic [9:0] c_v_vis_start = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] c_v_vis_end   = 10'(V_SYNC + V_BACK + V_VISIBLE);
    localparam logic [7:0] c_frame_last  = 8'(FRAME_DIV - 1);

    logic [3:0] r_div;
    logic       r_pix_en;
    logic [9:0] r_h_count;
    logic [9:0] r_v_count;
    logic [7:0] r_frame_cnt;
    logic       r_frame_tick;
    logic       r_game_tick;

    logic w_div_wrap;
    logic w_h_wrap;
    logic w_v_wrap;
    logic w_frame_wrap;
    logic w_game_wrap;
    logic w_h_visible;
    logic w_v_visible;

    assign w_div_wrap   = (r_div == c_div_last);
    assign w_h_wrap     = (r_h_count == c_h_last);
    assign w_v_wrap     = (r_v_count == c_v_last);
    // The edge that returns the raster to (0,0); ticks register off it so they
    // line up with the first cycle that reads (0,0).
    assign w_frame_wrap = r_pix_en & w_h_wrap & w_v_wrap;
    assign w_game_wrap  = w_frame_wrap & (r_frame_cnt == c_frame_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div    <= 4'd0;
            r_pix_en <= 1'b0;
        end else begin
            r_div    <= w_div_wrap ? 4'd0 : r_div + 4'd1;
            r_pix_en <= w_div_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h_count <= 10'd0;
            r_v_count <= 10'd0;
        end else if (r_pix_en) begin
            if (w_h_wrap) begin
                r_h_count <= 10'd0;
                r_v_count <= w_v_wrap ? 10'd0 : r_v_count + 10'd1;
            end else begin
                r_h_count <= r_h_count + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt  <= 8'd0;
            r_frame_tick <= 1'b0;
            r_game_tick  <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_wrap;
            r_game_tick  <= w_game_wrap;
            if (w_frame_wrap) begin
                r_frame_cnt <= w_game_wrap ? 8'd0 : r_frame_cnt + 8'd1;
            end
        end
    end

    // Decoded straight from the count registers so syncs/bright carry no skew.
    assign w_h_visible = (r_h_count >= c_h_vis_start) && (r_h_count < c_h_vis_end);
    assign w_v_visible = (r_v_count >= c_v_vis_start) && (r_v_count < c_v_vis_end);

    assign vga.pix_en     = r_pix_en;
    assign vga.hCount     = r_h_count;
    assign vga.vCount     = r_v_count;
    assign vga.hSync      = (r_h_count >= c_h_sync_end);
    assign vga.vSync      = (r_v_count >= c_v_sync_end);
    assign vga.bright     = w_h_visible & w_v_visible;
    assign vga.frame_tick = r_frame_tick;
    assign vga.game_tick  = r_game_tick;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Upstream stage of block_controller. Generates the 640x480@60 Hz VGA raster: hCount/vCount, bright, and active-low hSync/vSync. It also produces per-frame and game-rate tick pulses, so the game logic advances once per N frames instead of running from a free-running slow clock. All outputs are in the 100 MHz clk domain.

Parameters:
CLK_DIV, 4, clk cycles per pixel (100 MHz / 4 = 25 MHz pixel rate); legal range 1..16.
H_TOTAL, 800, pixels per line.
V_TOTAL, 525, lines per frame.
FRAME_DIV, 2, frames per game_tick; legal range 1..255.

Ports:
clk  input  1  system clock, 100 MHz.
rst  input  1  reset; asynchronous assertion, active-low (0 = reset).
pix_en  output  1  one-clk pulse once every CLK_DIV clks; counters advance only on this pulse.
hCount  output  10  horizontal position, 0..H_TOTAL-1.
vCount  output  10  vertical position, 0..V_TOTAL-1.
hSync  output  1  horizontal sync, active-low.
vSync  output  1  vertical sync, active-low.
bright  output  1  high only inside the visible area.
frame_tick  output  1  one-clk pulse when the raster wraps to (0,0).
game_tick  output  1  one-clk pulse on every FRAME_DIV-th frame_tick.

Behaviour:
- Reset (rst=0, asynchronous): clock divider=0, hCount=0, vCount=0, frame counter=0, pix_en=0, frame_tick=0, game_tick=0.
- During reset, hSync=0 and vSync=0 (count 0 lies in the sync region). bright=0.
- Reset deassertion: counting starts on the first clk edge with rst=1.
- Divider: 0..CLK_DIV-1, wraps to 0. pix_en is registered and is high for exactly the one clk after the divider reaches CLK_DIV-1.
- First pix_en after reset release: clk edge number CLK_DIV. With CLK_DIV=1, pix_en is high on every clk after reset.
- hCount increments on pix_en. At H_TOTAL-1 it wraps to 0, and on that same pix_en vCount increments.
- vCount wraps from V_TOTAL-1 to 0. Counters hold between pix_en pulses.
- Horizontal regions (hCount): sync 0..95 (hSync=0), back porch 96..143, visible 144..783, front porch 784..799.
- Vertical regions (vCount): sync 0..1 (vSync=0), back porch 2..34, visible 35..514, front porch 515..524.
- bright = (144<=hCount<=783) && (35<=vCount<=514). Top-left visible pixel is (144,35); bottom-right is (783,514).
- hSync, vSync and bright are decoded from the counter registers, valid in the same cycle as the counts: 0-cycle latency relative to hCount/vCount, no pipeline skew.
- frame_tick: registered. High for exactly one clk, in the cycle where the counters first read (0,0), i.e. the clk after the wrap edge.
- Frame counter: 0..FRAME_DIV-1, increments on each frame_tick event.
- game_tick: high in the same clk as the frame_tick that wraps the frame counter back to 0. With FRAME_DIV=1, game_tick equals frame_tick.
- No frame_tick or game_tick is emitted at reset release; the first frame_tick follows a full frame.
- Arithmetic: all counters are unsigned. Comparisons use the full 10-bit width; there is no overflow, since the maximum count is 799.
- Reset mid-frame: all state returns to reset values immediately. No partial tick pulse may be emitted.
- No inputs other than clk/rst; the block is free-running.

Test Plan:
- Reset held 10 clks, then released, CLK_DIV=4 -> pix_en first high on the 4th clk edge after release, then every 4 clks. hCount=1 after the first pix_en.
- Run one full line -> hSync low for exactly 96 pix_en periods (384 clks). hCount wraps 799->0 and vCount goes 0->1 on the same pix_en.
- Run one full frame -> 800*525*4 = 1,680,000 clks between consecutive frame_ticks. vSync low for 2 lines (1600 pixels). bright high for exactly 640*480 = 307,200 pixel periods.
- Check bright boundaries -> bright=0 at (143,35), 1 at (144,35), 1 at (783,514), 0 at (784,514), 0 at (144,515).
- FRAME_DIV=2 over 5 frames -> frame_tick 5 pulses. game_tick coincides with the 2nd and 4th frame_tick, each exactly 1 clk wide.
- Assert rst=0 asynchronously mid-line at hCount=400 -> hCount, vCount, pix_en and both ticks go to 0 before the next clk edge. After release, the first frame_tick arrives 1,680,000 clks later.
